// File: rtl/reg_sel_decoder.sv
// Register-select decoder: encoded select codes become one-hot load-enable pulses
// (write side, multi-cycle with ready handshake) and a held one-hot bus output enable.
module reg_sel_decoder #(
   parameter int unsigned                 SEL_W     = 4,
   parameter logic [(2**SEL_W)-1:0]       RSV_MASK  = 16'hE00D,
   parameter int unsigned                 LD_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_req,
   input  logic [SEL_W-1:0]         wr_sel,
   output logic                     wr_ready,
   output logic [(2**SEL_W)-1:0]    ld_en,
   input  logic                     rd_en,
   input  logic [SEL_W-1:0]         rd_sel,
   input  logic                     rd_clr,
   output logic [(2**SEL_W)-1:0]    oe,
   output logic                     err,
   input  logic                     err_clr,
   output logic                     conflict
);

   localparam int unsigned          N_OUT  = 2**SEL_W;
   localparam logic [3:0]           LD_CNT = 4'(LD_CYCLES);
   localparam logic [N_OUT-1:0]     ONE    = {{(N_OUT-1){1'b0}}, 1'b1};

   typedef enum logic {
      S_IDLE,
      S_LOAD
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_cnt;
   logic [3:0]          w_cnt_nxt;
   logic [N_OUT-1:0]    r_ld_oh;
   logic [N_OUT-1:0]    w_ld_oh_nxt;
   logic [N_OUT-1:0]    r_oe;
   logic [N_OUT-1:0]    w_oe_nxt;
   logic                r_err;
   logic                w_err_nxt;
   logic                w_wr_err;
   logic                w_rd_err;
   logic                w_wr_valid;
   logic                w_rd_valid;
   logic [N_OUT-1:0]    w_wr_dec;
   logic [N_OUT-1:0]    w_rd_dec;

   assign w_wr_valid = ~RSV_MASK[wr_sel];
   assign w_rd_valid = ~RSV_MASK[rd_sel];
   assign w_wr_dec   = ONE << wr_sel;
   assign w_rd_dec   = ONE << rd_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ld_oh <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ld_oh <= w_ld_oh_nxt;
      end
   end

   // ld_en is held in r_ld_oh for the whole LOAD dwell and cleared on the exit edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ld_oh_nxt = r_ld_oh;
      w_wr_err    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (wr_req) begin
               if (w_wr_valid) begin
                  w_ld_oh_nxt = w_wr_dec;
                  w_cnt_nxt   = LD_CNT;
                  w_state_nxt = S_LOAD;
               end else begin
                  w_wr_err    = 1'b1;
               end
            end
         end
         S_LOAD: begin
            if (r_cnt <= 4'd1) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_ld_oh_nxt = '0;
            end else begin
               w_cnt_nxt   = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_ld_oh_nxt = '0;
         end
      endcase
   end

   always_comb begin
      w_oe_nxt = r_oe;
      w_rd_err = 1'b0;
      if (rd_en) begin
         if (w_rd_valid) begin
            w_oe_nxt = w_rd_dec;
         end else begin
            w_rd_err = 1'b1;
         end
      end else if (rd_clr) begin
         w_oe_nxt = '0;
      end
   end

   assign w_err_nxt = w_wr_err | w_rd_err | (r_err & ~err_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_oe  <= '0;
         r_err <= 1'b0;
      end else begin
         r_oe  <= w_oe_nxt;
         r_err <= w_err_nxt;
      end
   end

   assign wr_ready = (r_state == S_IDLE);
   assign ld_en    = r_ld_oh;
   assign oe       = r_oe;
   assign err      = r_err;
   assign conflict = |(r_ld_oh & r_oe);

endmodule

// File: tb/tb_reg_sel_decoder.sv
// Scoreboard bench for reg_sel_decoder: two instances (1- and 3-cycle load pulse)
// share stimulus; a spec-level model queues expected outputs for each edge.
module tb_reg_sel_decoder;

   logic          clk;
   logic          rst_n;
   logic          wr_req;
   logic [3:0]    wr_sel;
   logic          rd_en;
   logic [3:0]    rd_sel;
   logic          rd_clr;
   logic          err_clr;
   logic          wr_ready [2];
   logic [15:0]   ld_en    [2];
   logic [15:0]   oe       [2];
   logic          err      [2];
   logic          conflict [2];

   int unsigned   n_checks = 0;
   int unsigned   n_errors = 0;

   reg_sel_decoder #(.SEL_W(4), .RSV_MASK(16'hE00D), .LD_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_sel(wr_sel), .wr_ready(wr_ready[0]),
      .ld_en(ld_en[0]), .rd_en(rd_en), .rd_sel(rd_sel), .rd_clr(rd_clr), .oe(oe[0]),
      .err(err[0]), .err_clr(err_clr), .conflict(conflict[0])
   );

   reg_sel_decoder #(.SEL_W(4), .RSV_MASK(16'hE00D), .LD_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_sel(wr_sel), .wr_ready(wr_ready[1]),
      .ld_en(ld_en[1]), .rd_en(rd_en), .rd_sel(rd_sel), .rd_clr(rd_clr), .oe(oe[1]),
      .err(err[1]), .err_clr(err_clr), .conflict(conflict[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] ld  [2];
      logic [15:0] oe  [2];
      logic        err [2];
      logic        rdy [2];
      logic        cf  [2];
   } exp_t;

   exp_t          sb_q [$];

   // Model state: pulse cycles still to come, latched load code, bus enable, err.
   int unsigned   m_left [2];
   logic [15:0]   m_code [2];
   logic [15:0]   m_oe   [2];
   logic          m_err  [2];
   int unsigned   m_len  [2];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic code_ok(input logic [3:0] c);
      logic [15:0] rsv;
      rsv = 16'hE00D;
      return !rsv[c];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_left[d] = 0;
         m_code[d] = '0;
         m_oe[d]   = '0;
         m_err[d]  = 1'b0;
      end
   endtask

   task automatic model_edge();
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         logic bad;
         bad = 1'b0;
         if (m_left[d] != 0) begin
            m_left[d] = m_left[d] - 1;
         end else if (wr_req) begin
            if (code_ok(wr_sel)) begin
               m_code[d] = 16'd1 << wr_sel;
               m_left[d] = m_len[d];
            end else begin
               bad = 1'b1;
            end
         end
         if (rd_en) begin
            if (code_ok(rd_sel)) m_oe[d] = 16'd1 << rd_sel;
            else bad = 1'b1;
         end else if (rd_clr) begin
            m_oe[d] = '0;
         end
         m_err[d] = bad || (m_err[d] && !err_clr);
         e.ld[d]  = (m_left[d] != 0) ? m_code[d] : 16'h0000;
         e.oe[d]  = m_oe[d];
         e.err[d] = m_err[d];
         e.rdy[d] = (m_left[d] == 0);
         e.cf[d]  = |(e.ld[d] & m_oe[d]);
      end
      sb_q.push_back(e);
   endtask

   task automatic compare_outputs(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      for (int d = 0; d < 2; d++) begin
         string p;
         p = $sformatf("%s_d%0d", tag, d);
         check_val({p, "_ld_en"},    {16'h0, ld_en[d]}, {16'h0, e.ld[d]});
         check_val({p, "_oe"},       {16'h0, oe[d]},    {16'h0, e.oe[d]});
         check_val({p, "_err"},      {31'h0, err[d]},      {31'h0, e.err[d]});
         check_val({p, "_wr_ready"}, {31'h0, wr_ready[d]}, {31'h0, e.rdy[d]});
         check_val({p, "_conflict"}, {31'h0, conflict[d]}, {31'h0, e.cf[d]});
      end
   endtask

   task automatic cycle(input string tag, input logic wq, input logic [3:0] ws,
                        input logic re, input logic [3:0] rs, input logic rc, input logic ec);
      wr_req  = wq;
      wr_sel  = ws;
      rd_en   = re;
      rd_sel  = rs;
      rd_clr  = rc;
      err_clr = ec;
      model_edge();
      @(posedge clk);
      #1;
      compare_outputs(tag);
   endtask

   task automatic idle(input string tag, input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cycle(tag, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic check_reset_state(input string tag);
      for (int d = 0; d < 2; d++) begin
         string p;
         p = $sformatf("%s_d%0d", tag, d);
         check_val({p, "_ld_en"},    {16'h0, ld_en[d]},    32'h0);
         check_val({p, "_oe"},       {16'h0, oe[d]},       32'h0);
         check_val({p, "_err"},      {31'h0, err[d]},      32'h0);
         check_val({p, "_wr_ready"}, {31'h0, wr_ready[d]}, 32'h1);
         check_val({p, "_conflict"}, {31'h0, conflict[d]}, 32'h0);
      end
   endtask

   initial begin
      m_len[0] = 1;
      m_len[1] = 3;
      rst_n   = 1'b0;
      wr_req  = 1'b0;
      wr_sel  = '0;
      rd_en   = 1'b0;
      rd_sel  = '0;
      rd_clr  = 1'b0;
      err_clr = 1'b0;
      model_reset();
      #1;
      check_reset_state("reset");
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_hold");
      rst_n = 1'b1;

      // basic write, code 5
      cycle("wr5",      1'b1, 4'd5,  1'b0, 4'd0, 1'b0, 1'b0);
      idle("wr5_tail", 4);

      // long pulse with a request arriving during LOAD
      cycle("wr12",     1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b0);
      cycle("wr1_busy", 1'b1, 4'd1,  1'b0, 4'd0, 1'b0, 1'b0);
      idle("wr12_tail", 4);

      // invalid codes on both sides with a held oe
      cycle("rd4",      1'b0, 4'd0,  1'b1, 4'd4,  1'b0, 1'b0);
      cycle("wr_bad2",  1'b1, 4'd2,  1'b0, 4'd0,  1'b0, 1'b0);
      cycle("rd_bad14", 1'b0, 4'd0,  1'b1, 4'd14, 1'b0, 1'b0);
      idle("err_hold", 2);
      cycle("clr_set",  1'b1, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1);
      cycle("clr",      1'b0, 4'd0,  1'b0, 4'd0,  1'b0, 1'b1);
      idle("err_low", 1);

      // read priority over clear
      cycle("rd9_clr",  1'b0, 4'd0,  1'b1, 4'd9, 1'b1, 1'b0);
      idle("rd9_hold", 2);
      cycle("rd_clr",   1'b0, 4'd0,  1'b0, 4'd0, 1'b1, 1'b0);
      idle("rd_zero", 1);

      // conflict on matching code only
      cycle("rd7",      1'b0, 4'd0,  1'b1, 4'd7, 1'b0, 1'b0);
      cycle("wr7",      1'b1, 4'd7,  1'b0, 4'd0, 1'b0, 1'b0);
      idle("cf_tail", 4);
      cycle("wr8",      1'b1, 4'd8,  1'b0, 4'd0, 1'b0, 1'b0);
      idle("wr8_tail", 4);

      // boundary codes and simultaneous read/write activity
      cycle("wr4_rd12", 1'b1, 4'd4,  1'b1, 4'd12, 1'b0, 1'b0);
      idle("b_tail", 3);
      cycle("wr15_rd1", 1'b1, 4'd15, 1'b1, 4'd1,  1'b0, 1'b0);
      idle("b2_tail", 1);

      // random traffic
      for (int i = 0; i < 60; i++) begin
         cycle("rnd", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0));
      end
      idle("rnd_tail", 4);

      // async reset in the middle of a 3-cycle pulse, with oe and err set
      cycle("pre_rd10", 1'b0, 4'd0,  1'b1, 4'd10, 1'b0, 1'b0);
      cycle("pre_bad",  1'b1, 4'd13, 1'b0, 4'd0,  1'b0, 1'b0);
      cycle("pre_wr6",  1'b1, 4'd6,  1'b0, 4'd0,  1'b0, 1'b0);
      idle("mid_load", 1);
      check_val("pre_rst_ld3", {16'h0, ld_en[1]}, 32'h0000_0040);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_state("async_rst");
      model_reset();
      sb_q.delete();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      cycle("post_wr11", 1'b1, 4'd11, 1'b0, 4'd0, 1'b0, 1'b0);
      idle("post_tail", 4);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
